// File: rtl/trng_pkg.sv
// ============================================================================
// Module   : trng_pkg
// Brief    : Shared constants and types for the TRNG bit collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package trng_pkg;

    localparam int c_DEF_WIDTH       = 8;
    localparam int c_DEF_SYNC_STAGES = 2;
    localparam int c_DEF_DISC_W      = 16;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        VN_NONE = 2'd0,
        VN_ZERO = 2'd1,
        VN_ONE  = 2'd2
    } vn_e;

    // Von Neumann rule: 10 -> 1, 01 -> 0, equal pairs carry no entropy.
    function automatic vn_e vn_decode(input logic b0, input logic b1);
        if (b0 == b1) begin
            return VN_NONE;
        end
        return b0 ? VN_ONE : VN_ZERO;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trng_sync_edge.sv
// ============================================================================
// Module   : trng_sync_edge
// Brief    : Multi-flop synchronizer with rising-edge pulse output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trng_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic tick_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign tick_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/trng_bit_collector.sv
// ============================================================================
// Module   : trng_bit_collector
// Brief    : Samples raw entropy on sample_clk edges, von Neumann debiases
//            pairs and packs accepted bits into words on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trng_bit_collector
    import trng_pkg::*;
#(
    parameter int WIDTH       = c_DEF_WIDTH,
    parameter int SYNC_STAGES = c_DEF_SYNC_STAGES,
    parameter int DISC_W      = c_DEF_DISC_W
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              sample_clk,
    input  logic              raw_bit,
    output logic [WIDTH-1:0]  rnd_word,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              overrun,
    output logic [DISC_W-1:0] disc_cnt
);

    localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic w_tick;
    logic w_sclk_level_unused;
    logic w_sample;
    logic w_raw_tick_unused;

    // Both paths share the same depth so the sample lines up with its tick.
    trng_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk_in  (clk_in),
        .reset   (reset),
        .async_i (sample_clk),
        .level_o (w_sclk_level_unused),
        .tick_o  (w_tick)
    );

    trng_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_raw (
        .clk_in  (clk_in),
        .reset   (reset),
        .async_i (raw_bit),
        .level_o (w_sample),
        .tick_o  (w_raw_tick_unused)
    );

    state_e             state_q;
    logic               b0_q;
    logic [WIDTH-2:0]   sr_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   word_q;
    logic               valid_q;
    logic               overrun_q;
    logic [DISC_W-1:0]  disc_q;

    vn_e              w_vn;
    logic             w_accept;
    logic             w_discard;
    logic             w_complete;
    logic             w_xfer;
    logic [WIDTH-1:0] word_d;

    always_comb begin
        w_vn = VN_NONE;
        if (w_tick && (state_q == SECOND)) begin
            w_vn = vn_decode(b0_q, w_sample);
        end
        w_accept   = (w_vn == VN_ONE) || (w_vn == VN_ZERO);
        w_discard  = w_tick && (state_q == SECOND) && (w_vn == VN_NONE);
        w_complete = w_accept && (cnt_q == c_LAST);
        w_xfer     = valid_q & rnd_ready;
        word_d     = {sr_q, (w_vn == VN_ONE)};
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= FIRST;
            b0_q      <= 1'b0;
            sr_q      <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            disc_q    <= '0;
        end else begin
            if (w_tick) begin
                if (state_q == FIRST) begin
                    b0_q    <= w_sample;
                    state_q <= SECOND;
                end else begin
                    state_q <= FIRST;
                end
            end

            if (w_discard && (disc_q != '1)) begin
                disc_q <= disc_q + 1'b1;
            end

            // Stale bits need no clearing: a full word shifts them all out.
            if (w_accept) begin
                sr_q  <= word_d[WIDTH-2:0];
                cnt_q <= w_complete ? '0 : cnt_q + 1'b1;
            end

            if (w_complete) begin
                if (!valid_q || rnd_ready) begin
                    word_q  <= word_d;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (w_xfer) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rnd_word  = word_q;
    assign rnd_valid = valid_q;
    assign overrun   = overrun_q;
    assign disc_cnt  = disc_q;

endmodule

`default_nettype wire

// File: tb/tb_trng_bit_collector.sv
// ============================================================================
// Module   : tb_trng_bit_collector
// Brief    : Self-checking bench for trng_bit_collector with a pair-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trng_bit_collector;

    localparam int WIDTH = 8;
    localparam int SS    = 2;

    logic             clk_in     = 1'b0;
    logic             reset      = 1'b1;
    logic             sample_clk = 1'b0;
    logic             raw_bit    = 1'b0;
    logic             rnd_ready  = 1'b0;
    logic [WIDTH-1:0] rnd_word;
    logic             rnd_valid;
    logic             overrun;
    logic [15:0]      disc_cnt;
    logic [WIDTH-1:0] rnd_word4;
    logic             rnd_valid4;
    logic             overrun4;
    logic [3:0]       disc_cnt4;

    trng_bit_collector #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .DISC_W(16)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .sample_clk (sample_clk),
        .raw_bit    (raw_bit),
        .rnd_word   (rnd_word),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .overrun    (overrun),
        .disc_cnt   (disc_cnt)
    );

    // Narrow discard counter instance, used for the saturation check.
    trng_bit_collector #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .DISC_W(4)) dut4 (
        .clk_in     (clk_in),
        .reset      (reset),
        .sample_clk (sample_clk),
        .raw_bit    (raw_bit),
        .rnd_word   (rnd_word4),
        .rnd_valid  (rnd_valid4),
        .rnd_ready  (rnd_ready),
        .overrun    (overrun4),
        .disc_cnt   (disc_cnt4)
    );

    always #5 clk_in = ~clk_in;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] got_q[$];
    int               valid_cycles = 0;
    logic [WIDTH-1:0] comp_q[$];
    bit               acc_q[$];
    int               disc_model = 0;

    always @(negedge clk_in) begin
        if (!reset) begin
            if (rnd_valid) valid_cycles++;
            if (rnd_valid && rnd_ready) got_q.push_back(rnd_word);
        end
    end

    // Reference: pairs -> accepted bits (first bit of a differing pair) -> words, MSB first.
    function automatic void model_pair(input bit a, input bit b);
        logic [WIDTH-1:0] w;
        if (a != b) begin
            acc_q.push_back(a);
            if (acc_q.size() == WIDTH) begin
                w = '0;
                foreach (acc_q[i]) w = {w[WIDTH-2:0], acc_q[i]};
                comp_q.push_back(w);
                acc_q.delete();
            end
        end else begin
            disc_model++;
        end
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    task automatic send_sample(input bit b);
        raw_bit    = b;
        sample_clk = 1'b1;
        step($urandom_range(1, 3));
        sample_clk = 1'b0;
        step($urandom_range(1, 3));
    endtask

    task automatic feed_pair(input bit a, input bit b);
        send_sample(a);
        send_sample(b);
        model_pair(a, b);
    endtask

    task automatic feed_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w[i]) feed_pair(1'b1, 1'b0);
            else      feed_pair(1'b0, 1'b1);
        end
    endtask

    task automatic reset_dut();
        sample_clk = 1'b0;
        reset      = 1'b1;
        step(2);
        reset      = 1'b0;
        acc_q.delete();
        disc_model = 0;
        step(1);
    endtask

    task automatic test_reset();
        int first_tick;
        int ticks;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample_clk = ~sample_clk;
            raw_bit    = 1'($urandom);
            step(1);
            @(negedge clk_in);
            checks++;
            if ({rnd_word, rnd_valid, overrun, disc_cnt} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: word=%h valid=%b ovr=%b disc=%0d, required all 0",
                         c, rnd_word, rnd_valid, overrun, disc_cnt);
            end
        end
        sample_clk = 1'b1;
        step(1);
        reset      = 1'b0;
        first_tick = -1;
        ticks      = 0;
        for (int c = 1; c <= SS + 5; c++) begin
            @(negedge clk_in);
            if (dut.w_tick) begin
                ticks++;
                if (first_tick < 0) first_tick = c;
            end
        end
        checks++;
        if (ticks != 1 || first_tick < SS) begin
            errors++;
            $display("FAIL reset_release_tick: ticks=%0d first_cycle=%0d, required 1 tick at cycle >= %0d",
                     ticks, first_tick, SS);
        end
        reset_dut();
    endtask

    task automatic test_packing();
        int g0 = got_q.size();
        int v0 = valid_cycles;
        rnd_ready = 1'b1;
        feed_word(8'hB2);
        step(SS + 4);
        checks++;
        if (got_q.size() != g0 + 1 || got_q[g0] !== 8'hB2) begin
            errors++;
            $display("FAIL packing_word: got %0d words first=%h, required 1 word b2",
                     got_q.size() - g0, got_q.size() > g0 ? got_q[g0] : 8'h00);
        end
        checks++;
        if (valid_cycles - v0 != 1) begin
            errors++;
            $display("FAIL packing_valid_width: valid high %0d cycles, required 1", valid_cycles - v0);
        end
        checks++;
        if (disc_cnt !== 16'd0) begin
            errors++;
            $display("FAIL packing_disc: disc_cnt=%0d, required 0", disc_cnt);
        end
    endtask

    task automatic test_discard();
        int g0;
        int rem = 5;
        logic [WIDTH-1:0] w = 8'hB2;
        bit d;
        reset_dut();
        g0 = got_q.size();
        rnd_ready = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            while (rem > 0 && $urandom_range(0, 1) == 1) begin
                d = 1'($urandom);
                feed_pair(d, d);
                rem--;
            end
            if (w[i]) feed_pair(1'b1, 1'b0);
            else      feed_pair(1'b0, 1'b1);
        end
        while (rem > 0) begin
            d = 1'($urandom);
            feed_pair(d, d);
            rem--;
        end
        step(SS + 4);
        checks++;
        if (got_q.size() != g0 + 1 || got_q[g0] !== 8'hB2) begin
            errors++;
            $display("FAIL discard_word: got %0d words first=%h, required 1 word b2",
                     got_q.size() - g0, got_q.size() > g0 ? got_q[g0] : 8'h00);
        end
        checks++;
        if (disc_cnt !== 16'd5) begin
            errors++;
            $display("FAIL discard_count: disc_cnt=%0d, required 5", disc_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            d = 1'($urandom);
            feed_pair(d, d);
        end
        step(SS + 4);
        checks++;
        if (disc_cnt !== 16'(disc_model)) begin
            errors++;
            $display("FAIL discard_count_wide: disc_cnt=%0d, required %0d", disc_cnt, disc_model);
        end
        checks++;
        if (disc_cnt4 !== 4'((disc_model > 15) ? 15 : disc_model)) begin
            errors++;
            $display("FAIL discard_saturate: disc_cnt4=%0d, required 15", disc_cnt4);
        end
    endtask

    task automatic test_backpressure();
        int g0;
        reset_dut();
        rnd_ready = 1'b0;
        g0 = got_q.size();
        feed_word(8'hB2);
        feed_word(8'h4D);
        step(SS + 4);
        @(negedge clk_in);
        checks++;
        if (rnd_word !== 8'hB2 || rnd_valid !== 1'b1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_hold: word=%h valid=%b ovr=%b, required b2 1 1",
                     rnd_word, rnd_valid, overrun);
        end
        step(1);
        rnd_ready = 1'b1;
        step(1);
        rnd_ready = 1'b0;
        @(negedge clk_in);
        checks++;
        if (rnd_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_drain: valid=%b ovr=%b, required 0 1", rnd_valid, overrun);
        end
        checks++;
        if (got_q.size() != g0 + 1 || got_q[g0] !== 8'hB2) begin
            errors++;
            $display("FAIL backpressure_xfer: got %0d words first=%h, required 1 word b2",
                     got_q.size() - g0, got_q.size() > g0 ? got_q[g0] : 8'h00);
        end
    endtask

    task automatic test_simultaneous();
        int g0;
        logic [WIDTH-1:0] w = 8'h4D;
        reset_dut();
        rnd_ready = 1'b0;
        g0 = got_q.size();
        feed_word(8'hB2);
        step(SS + 4);
        for (int i = WIDTH - 1; i >= 1; i--) begin
            if (w[i]) feed_pair(1'b1, 1'b0);
            else      feed_pair(1'b0, 1'b1);
        end
        send_sample(1'b1);
        raw_bit    = 1'b0;
        sample_clk = 1'b1;
        step(SS);
        rnd_ready = 1'b1;
        step(1);
        rnd_ready = 1'b0;
        model_pair(1'b1, 1'b0);
        @(negedge clk_in);
        checks++;
        if (rnd_word !== 8'h4D || rnd_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous: word=%h valid=%b ovr=%b, required 4d 1 0",
                     rnd_word, rnd_valid, overrun);
        end
        sample_clk = 1'b0;
        step(2);
        rnd_ready = 1'b1;
        step(3);
        checks++;
        if (got_q.size() != g0 + 2 || got_q[g0] !== 8'hB2 || got_q[g0+1] !== 8'h4D) begin
            errors++;
            $display("FAIL simultaneous_xfers: got %0d words, required b2 then 4d", got_q.size() - g0);
        end
    endtask

    task automatic test_mid_word_reset();
        int g0;
        reset_dut();
        rnd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 1) == 1) feed_pair(1'b1, 1'b0);
            else                           feed_pair(1'b0, 1'b1);
        end
        reset_dut();
        g0 = got_q.size();
        feed_word(8'hB2);
        step(SS + 4);
        checks++;
        if (got_q.size() != g0 + 1 || got_q[g0] !== 8'hB2) begin
            errors++;
            $display("FAIL midword_reset: got %0d words first=%h, required 1 word b2",
                     got_q.size() - g0, got_q.size() > g0 ? got_q[g0] : 8'h00);
        end
        send_sample(1'($urandom));
        reset_dut();
        g0 = got_q.size();
        feed_word(8'hB2);
        step(SS + 4);
        checks++;
        if (got_q.size() != g0 + 1 || got_q[g0] !== 8'hB2) begin
            errors++;
            $display("FAIL midpair_reset: got %0d words first=%h, required 1 word b2",
                     got_q.size() - g0, got_q.size() > g0 ? got_q[g0] : 8'h00);
        end
    endtask

    task automatic test_random();
        int g0;
        int c0;
        reset_dut();
        rnd_ready = 1'b1;
        g0 = got_q.size();
        c0 = comp_q.size();
        for (int i = 0; i < 60; i++) begin
            feed_pair(1'($urandom), 1'($urandom));
        end
        step(SS + 4);
        checks++;
        if (got_q.size() - g0 != comp_q.size() - c0) begin
            errors++;
            $display("FAIL random_count: got %0d words, required %0d",
                     got_q.size() - g0, comp_q.size() - c0);
        end else begin
            for (int i = 0; i < comp_q.size() - c0; i++) begin
                checks++;
                if (got_q[g0+i] !== comp_q[c0+i]) begin
                    errors++;
                    $display("FAIL random_word %0d: got %h, required %h", i, got_q[g0+i], comp_q[c0+i]);
                end
            end
        end
        checks++;
        if (disc_cnt !== 16'(disc_model)) begin
            errors++;
            $display("FAIL random_disc: disc_cnt=%0d, required %0d", disc_cnt, disc_model);
        end
    endtask

    initial begin
        test_reset();
        test_packing();
        test_discard();
        test_backpressure();
        test_simultaneous();
        test_mid_word_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
